// File: rtl/spatial_encoder_mm_if.sv
// Frame, memory-port and output bus of the multi-modality spatial encoder.
// No logic, so no latency. The master modport is the encoder and the slave
// modport is the surrounding pipeline. Handshakes are valid/ready on both frame sides.
interface spatial_encoder_mm_if #(
    parameter int HV_DIMENSION  = 2000,
    parameter int CHANNEL_WIDTH = 4,
    parameter int NUM_MOD       = 3,
    parameter int MAX_CH        = 128
);
    localparam int ADDR_W = (MAX_CH > 1) ? $clog2(MAX_CH) : 1;
    localparam int CNT_W  = $clog2(MAX_CH + 2);

    logic                                      ValidIn_SI;
    logic                                      ReadyOut_SO;
    logic [NUM_MOD*MAX_CH*CHANNEL_WIDTH-1:0]   ChannelsInput_DI;
    logic [NUM_MOD*CNT_W-1:0]                  ChCount_DI;
    logic [NUM_MOD-1:0]                        MemReq_SO;
    logic [NUM_MOD*ADDR_W-1:0]                 MemAddr_DO;
    logic [NUM_MOD-1:0]                        MemValid_SI;
    logic [NUM_MOD*HV_DIMENSION-1:0]           IM_DI;
    logic [NUM_MOD*HV_DIMENSION-1:0]           ProjPos_DI;
    logic [NUM_MOD*HV_DIMENSION-1:0]           ProjNeg_DI;
    logic [HV_DIMENSION-1:0]                   HypervectorOut_DO;
    logic                                      ValidOut_SO;
    logic                                      ReadyIn_SI;

    modport master (
        input  ValidIn_SI, ChannelsInput_DI, ChCount_DI, MemValid_SI,
               IM_DI, ProjPos_DI, ProjNeg_DI, ReadyIn_SI,
        output ReadyOut_SO, MemReq_SO, MemAddr_DO, HypervectorOut_DO, ValidOut_SO
    );

    modport slave (
        output ValidIn_SI, ChannelsInput_DI, ChCount_DI, MemValid_SI,
               IM_DI, ProjPos_DI, ProjNeg_DI, ReadyIn_SI,
        input  ReadyOut_SO, MemReq_SO, MemAddr_DO, HypervectorOut_DO, ValidOut_SO
    );
endinterface

// File: rtl/spatial_encoder_mm.sv
// Binds per-channel item/projection HVs, bundles each modality by majority and fuses modalities by majority.
// Output is valid max(Nm)+2 cycles after frame accept; each memory stall on the slowest modality adds one cycle.
// Frame input is accepted only in IDLE. The output is held until ReadyIn_SI. Optional even-count tiebreak: SPATIAL_ENC_TIEBREAK_EN.
module spatial_encoder_mm #(
    parameter int HV_DIMENSION  = 2000,
    parameter int CHANNEL_WIDTH = 4,
    parameter int NUM_MOD       = 3,
    parameter int MAX_CH        = 128
) (
    input  logic                  Clk_CI,
    input  logic                  Reset_RI,
    spatial_encoder_mm_if.master  bus
);
    localparam int ADDR_W = (MAX_CH > 1) ? $clog2(MAX_CH) : 1;
    localparam int CNT_W  = $clog2(MAX_CH + 2);
    localparam int FEAT_W = NUM_MOD * MAX_CH * CHANNEL_WIDTH;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CH);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINAL, S_DONE} state_t;

    state_t                   r_state;
    logic                     r_ready;
    logic                     r_valid;
    logic [HV_DIMENSION-1:0]  r_hv;
    logic [FEAT_W-1:0]        r_feat;
    logic [CNT_W-1:0]         r_nm  [NUM_MOD];
    logic [CNT_W-1:0]         r_ch  [NUM_MOD];
    logic [CNT_W-1:0]         r_cnt [NUM_MOD][HV_DIMENSION];
`ifdef SPATIAL_ENC_TIEBREAK_EN
    logic [HV_DIMENSION-1:0]  r_tb  [NUM_MOD];
`endif

    logic                     w_accept;
    logic [NUM_MOD-1:0]       w_req;
    logic [NUM_MOD-1:0]       w_take;
    logic [NUM_MOD-1:0]       w_done;
    logic [ADDR_W-1:0]        w_addr    [NUM_MOD];
    logic [CHANNEL_WIDTH-1:0] w_feat    [NUM_MOD];
    logic [HV_DIMENSION-1:0]  w_bound   [NUM_MOD];
    logic [HV_DIMENSION-1:0]  w_mod_res [NUM_MOD];
    logic [HV_DIMENSION-1:0]  w_fused;

    // A zero count still walks one channel; oversize counts saturate at the memory depth.
    function automatic logic [CNT_W-1:0] clamp_cnt(input logic [CNT_W-1:0] c);
        if (c == '0)
            return ONE;
        else if (c > MAX_CNT)
            return MAX_CNT;
        else
            return c;
    endfunction

    assign w_accept        = (r_state == S_IDLE) && r_ready && bus.ValidIn_SI;
    assign bus.ReadyOut_SO = r_ready;
    assign bus.ValidOut_SO = r_valid;
    assign bus.HypervectorOut_DO = r_hv;
    assign bus.MemReq_SO   = w_req;

    // Per-modality memory walk, feature select and sign-selected binding.
    always_comb begin
        bus.MemAddr_DO = '0;
        for (int m = 0; m < NUM_MOD; m++) begin
            w_req[m]  = (r_state == S_RUN) && (r_ch[m] < r_nm[m]);
            w_take[m] = w_req[m] && bus.MemValid_SI[m];
            // Done either already, or after the channel consumed on this edge.
            w_done[m] = (r_ch[m] == r_nm[m]) ||
                        (w_take[m] && ((r_ch[m] + ONE) == r_nm[m]));
            w_addr[m] = w_req[m] ? r_ch[m][ADDR_W-1:0] : '0;
            bus.MemAddr_DO[m*ADDR_W +: ADDR_W] = w_addr[m];
            w_feat[m] = r_feat[(m*MAX_CH + int'(w_addr[m]))*CHANNEL_WIDTH +: CHANNEL_WIDTH];
            if (w_feat[m] == '0)
                w_bound[m] = '0;
            else if (w_feat[m][CHANNEL_WIDTH-1])
                w_bound[m] = bus.IM_DI[m*HV_DIMENSION +: HV_DIMENSION] ^
                             bus.ProjNeg_DI[m*HV_DIMENSION +: HV_DIMENSION];
            else
                w_bound[m] = bus.IM_DI[m*HV_DIMENSION +: HV_DIMENSION] ^
                             bus.ProjPos_DI[m*HV_DIMENSION +: HV_DIMENSION];
        end
    end

    // Per-modality strict majority over the bundled counts, then cross-modality majority.
    always_comb begin
        logic [CNT_W-1:0] v_sum;
        logic [CNT_W-1:0] v_ntot;
        logic [3:0]       v_votes;
        for (int m = 0; m < NUM_MOD; m++) begin
            for (int b = 0; b < HV_DIMENSION; b++) begin
`ifdef SPATIAL_ENC_TIEBREAK_EN
                // Even channel counts get one extra voter so ties cannot occur.
                if (!r_nm[m][0]) begin
                    v_sum  = r_cnt[m][b] + {{(CNT_W-1){1'b0}}, r_tb[m][b]};
                    v_ntot = r_nm[m] + ONE;
                end else begin
                    v_sum  = r_cnt[m][b];
                    v_ntot = r_nm[m];
                end
`else
                v_sum  = r_cnt[m][b];
                v_ntot = r_nm[m];
`endif
                w_mod_res[m][b] = v_sum > (v_ntot >> 1);
            end
        end
        for (int b = 0; b < HV_DIMENSION; b++) begin
            v_votes = '0;
            for (int m = 0; m < NUM_MOD; m++)
                v_votes = v_votes + {3'b000, w_mod_res[m][b]};
            w_fused[b] = v_votes > 4'(NUM_MOD / 2);
        end
    end

    // Frame control: latch frame, walk channels, load result, hold until taken.
    always_ff @(posedge Clk_CI or posedge Reset_RI) begin
        if (Reset_RI) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
            r_valid <= 1'b0;
            r_hv    <= '0;
            r_feat  <= '0;
            for (int m = 0; m < NUM_MOD; m++) begin
                r_nm[m] <= '0;
                r_ch[m] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_ready <= 1'b0;
                        r_feat  <= bus.ChannelsInput_DI;
                        for (int m = 0; m < NUM_MOD; m++) begin
                            r_nm[m] <= clamp_cnt(bus.ChCount_DI[m*CNT_W +: CNT_W]);
                            r_ch[m] <= '0;
                        end
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int m = 0; m < NUM_MOD; m++)
                        if (w_take[m])
                            r_ch[m] <= r_ch[m] + ONE;
                    if (&w_done)
                        r_state <= S_FINAL;
                end
                S_FINAL: begin
                    r_hv    <= w_fused;
                    r_valid <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    if (bus.ReadyIn_SI) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Per-bit ones counters (and tiebreak capture) advance on each consumed channel.
    always_ff @(posedge Clk_CI or posedge Reset_RI) begin
        if (Reset_RI) begin
            for (int m = 0; m < NUM_MOD; m++) begin
                for (int b = 0; b < HV_DIMENSION; b++)
                    r_cnt[m][b] <= '0;
`ifdef SPATIAL_ENC_TIEBREAK_EN
                r_tb[m] <= '0;
`endif
            end
        end else begin
            for (int m = 0; m < NUM_MOD; m++) begin
                if (w_accept) begin
                    for (int b = 0; b < HV_DIMENSION; b++)
                        r_cnt[m][b] <= '0;
`ifdef SPATIAL_ENC_TIEBREAK_EN
                    r_tb[m] <= '0;
`endif
                end else if (w_take[m]) begin
                    for (int b = 0; b < HV_DIMENSION; b++)
                        r_cnt[m][b] <= r_cnt[m][b] + {{(CNT_W-1){1'b0}}, w_bound[m][b]};
`ifdef SPATIAL_ENC_TIEBREAK_EN
                    // After channel 0 the counter LSB equals bound(ch0), so no copy is kept.
                    if (r_ch[m] == ONE)
                        for (int b = 0; b < HV_DIMENSION; b++)
                            r_tb[m][b] <= r_cnt[m][b][0] ^ w_bound[m][b];
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_spatial_encoder_mm.sv
// Directed bench for spatial_encoder_mm with 3 modalities, 4 channels and 8-bit hypervectors.
// A table-driven memory model answers each modality's address combinationally.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_spatial_encoder_mm;
    localparam int HV = 8;
    localparam int CW = 4;
    localparam int NM = 3;
    localparam int MC = 4;
    localparam int AW = 2;
    localparam int KW = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    spatial_encoder_mm_if #(.HV_DIMENSION(HV), .CHANNEL_WIDTH(CW), .NUM_MOD(NM), .MAX_CH(MC)) bus ();

    spatial_encoder_mm #(.HV_DIMENSION(HV), .CHANNEL_WIDTH(CW), .NUM_MOD(NM), .MAX_CH(MC)) dut (
        .Clk_CI   (clk),
        .Reset_RI (rst),
        .bus      (bus)
    );

    logic [HV-1:0] im_t [NM][MC];
    logic [HV-1:0] pp_t [NM][MC];
    logic [HV-1:0] pn_t [NM][MC];
    logic [CW-1:0] ft   [NM][MC];
    logic [KW-1:0] cnt_t [NM];

    int n_vec = 0;
    int n_err = 0;
    int cons [NM];

    // Memory model and frame packing
    always_comb begin
        logic [AW-1:0] a;
        bus.IM_DI = '0;
        bus.ProjPos_DI = '0;
        bus.ProjNeg_DI = '0;
        bus.ChannelsInput_DI = '0;
        bus.ChCount_DI = '0;
        for (int m = 0; m < NM; m++) begin
            a = bus.MemAddr_DO[m*AW +: AW];
            bus.IM_DI[m*HV +: HV]      = im_t[m][a];
            bus.ProjPos_DI[m*HV +: HV] = pp_t[m][a];
            bus.ProjNeg_DI[m*HV +: HV] = pn_t[m][a];
            bus.ChCount_DI[m*KW +: KW] = cnt_t[m];
            for (int c = 0; c < MC; c++)
                bus.ChannelsInput_DI[(m*MC+c)*CW +: CW] = ft[m][c];
        end
    end

    // Consumed-channel monitor
    always @(posedge clk)
        for (int m = 0; m < NM; m++)
            if (bus.MemReq_SO[m] && bus.MemValid_SI[m])
                cons[m] <= cons[m] + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_all();
        for (int m = 0; m < NM; m++) begin
            cnt_t[m] = 3'd1;
            for (int c = 0; c < MC; c++) begin
                im_t[m][c] = '0; pp_t[m][c] = '0; pn_t[m][c] = '0; ft[m][c] = '0;
            end
        end
    endtask

    task automatic set_ch(input int m, input int c, input logic [HV-1:0] im,
                          input logic [HV-1:0] pp, input logic [HV-1:0] pn, input logic [CW-1:0] f);
        im_t[m][c] = im; pp_t[m][c] = pp; pn_t[m][c] = pn; ft[m][c] = f;
    endtask

    // Leaves the bench 1 unit after the accept edge, i.e. in cycle 1.
    task automatic start_frame();
        bus.ValidIn_SI = 1'b1;
        tick();
        bus.ValidIn_SI = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int start_cyc, input int exp_cyc, input logic [HV-1:0] exp_hv);
        int cyc;
        int seen;
        cyc = start_cyc;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (bus.ValidOut_SO) begin
                seen = cyc;
                break;
            end
            tick();
            cyc++;
        end
        chk({tag, " valid cycle"}, seen, exp_cyc);
        chk({tag, " hv"}, bus.HypervectorOut_DO, exp_hv);
    endtask

    task automatic handshake(input string tag);
        tick();
        chk({tag, " valid dropped"}, bus.ValidOut_SO, 1'b0);
        chk({tag, " ready back"}, bus.ReadyOut_SO, 1'b1);
    endtask

    task automatic load_t1();
        clear_all();
        for (int m = 0; m < NM; m++) set_ch(m, 0, 8'hF0, 8'h0F, 8'h00, 4'h1);
    endtask

    task automatic load_t4();
        clear_all();
        for (int m = 0; m < NM; m++) cnt_t[m] = 3'd4;
        for (int c = 0; c < MC; c++) begin
            set_ch(0, c, 8'hFF, 8'h00, 8'h00, 4'h1);
            set_ch(1, c, (c == 3) ? 8'hF0 : 8'h0F, 8'h00, 8'h00, 4'h1);
            set_ch(2, c, (c < 2) ? 8'h0F : 8'h00, 8'h00, 8'h00, 4'h1);
        end
    endtask

    initial begin
        int seen;
        int c0 [NM];
        logic [7:0] exp_c;
        bus.ValidIn_SI = 1'b0;
        bus.ReadyIn_SI = 1'b1;
        bus.MemValid_SI = 3'b111;
        for (int m = 0; m < NM; m++) cons[m] = 0;
        clear_all();

        // Reset state
        #1 rst = 1'b1;
        #1;
        chk("rst ready", bus.ReadyOut_SO, 1'b0);
        chk("rst valid", bus.ValidOut_SO, 1'b0);
        chk("rst req", bus.MemReq_SO, 3'b000);
        chk("rst addr", bus.MemAddr_DO, 6'd0);
        chk("rst hv", bus.HypervectorOut_DO, 8'h00);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("ready after release", bus.ReadyOut_SO, 1'b1);

        // Counts 1,1,1, F0^0F per modality
        load_t1();
        start_frame();
        chk("t1 ready low in run", bus.ReadyOut_SO, 1'b0);
        wait_valid("t1", 1, 3, 8'hFF);
        handshake("t1");

        // Even count on modality 0: AA then 55, others 00
        clear_all();
        cnt_t[0] = 3'd2;
        set_ch(0, 0, 8'hAA, 8'h00, 8'h00, 4'h1);
        set_ch(0, 1, 8'h55, 8'h00, 8'h00, 4'h1);
        start_frame();
        wait_valid("t2a", 1, 4, 8'h00);
        handshake("t2a");
        set_ch(1, 0, 8'hFF, 8'h00, 8'h00, 4'h1);
        set_ch(2, 0, 8'hFF, 8'h00, 8'h00, 4'h1);
        start_frame();
        wait_valid("t2b", 1, 4, 8'hFF);
        handshake("t2b");
        // Split the other two modalities so the output exposes modality 0
        set_ch(2, 0, 8'h00, 8'h00, 8'h00, 4'h1);
`ifdef SPATIAL_ENC_TIEBREAK_EN
        exp_c = 8'hFF;
`else
        exp_c = 8'h00;
`endif
        start_frame();
        wait_valid("t2c", 1, 4, exp_c);
        handshake("t2c");

        // Sign selection: -8 uses ProjNeg, +3 uses ProjPos, 0 binds to zero
        clear_all();
        cnt_t[0] = 3'd3;
        set_ch(0, 0, 8'hFF, 8'h00, 8'h0F, 4'h8);
        set_ch(0, 1, 8'hFF, 8'h33, 8'h00, 4'h3);
        set_ch(0, 2, 8'hFF, 8'h00, 8'h00, 4'h0);
        set_ch(1, 0, 8'hFF, 8'h00, 8'h00, 4'h1);
        start_frame();
        wait_valid("t3", 1, 5, 8'hC0);
        handshake("t3");

        // Stall modality 1 at channel 2 for three cycles
        load_t4();
        start_frame();
        tick(); tick();
        bus.MemValid_SI = 3'b101;
        for (int k = 0; k < 3; k++) begin
            chk("t4 addr1 held", bus.MemAddr_DO[AW +: AW], 2'd2);
            chk("t4 req1 held", bus.MemReq_SO[1], 1'b1);
            if (k == 2) chk("t4 early done req", bus.MemReq_SO, 3'b010);
            tick();
        end
        bus.MemValid_SI = 3'b111;
        wait_valid("t4", 6, 9, 8'h0F);
        handshake("t4");

        // Downstream backpressure for five cycles; a new frame request is ignored
        load_t1();
        bus.ReadyIn_SI = 1'b0;
        start_frame();
        wait_valid("t5", 1, 3, 8'hFF);
        bus.ValidIn_SI = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t5 valid held", bus.ValidOut_SO, 1'b1);
            chk("t5 hv held", bus.HypervectorOut_DO, 8'hFF);
            chk("t5 ready low", bus.ReadyOut_SO, 1'b0);
        end
        bus.ValidIn_SI = 1'b0;
        bus.ReadyIn_SI = 1'b1;
        handshake("t5");
        chk("t5 no new frame", bus.MemReq_SO, 3'b000);
        tick();
        chk("t5 still idle", bus.ReadyOut_SO, 1'b1);

        // Reset in RUN cycle 2
        load_t4();
        start_frame();
        tick();
        rst = 1'b1;
        #1;
        chk("t6 req cleared", bus.MemReq_SO, 3'b000);
        chk("t6 valid low", bus.ValidOut_SO, 1'b0);
        chk("t6 ready low", bus.ReadyOut_SO, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        chk("t6 ready after release", bus.ReadyOut_SO, 1'b1);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (bus.ValidOut_SO) seen = 1;
        end
        chk("t6 no stale output", seen, 0);
        load_t1();
        start_frame();
        wait_valid("t6 next", 1, 3, 8'hFF);
        handshake("t6 next");

        // Count clamps: 0 -> 1 and 7 -> 4
        load_t4();
        cnt_t[0] = 3'd0;
        cnt_t[1] = 3'd7;
        cnt_t[2] = 3'd1;
        set_ch(2, 0, 8'h00, 8'h00, 8'h00, 4'h1);
        for (int m = 0; m < NM; m++) c0[m] = cons[m];
        start_frame();
        wait_valid("t7", 1, 6, 8'h0F);
        handshake("t7");
        chk("t7 mod0 channels", cons[0] - c0[0], 1);
        chk("t7 mod1 channels", cons[1] - c0[1], 4);
        chk("t7 mod2 channels", cons[2] - c0[2], 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
